prewish5k_blinky: RTL and testbench
===================================

PREWISH5K_BLINKY -- requirements
Module: prewish5k_blinky

Interface
REQ-001 Parameter TICK_COUNT, default 1500000, clock cycles per LED bit-period (legal range 2..2^24).
REQ-002 CLK_I  input  1  sole clock; all state changes on its rising edge.
REQ-003 RST_I  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 STB_I  input  1  student strobe from mentor; nominally a one-cycle high pulse.
REQ-005 DAT_I  input  8  blink mask; valid in the cycle STB_I is sampled high.
REQ-006 ACK_O  output 1  one-cycle pulse acknowledging each accepted strobe.
REQ-007 o_led  output 1  LED drive, the currently selected mask bit.
REQ-008 o_busy output 1  high while a pattern is playing (state RUN).
REQ-009 o_alive output 1  debug LED; toggles on every accepted strobe.

Function
REQ-010 Strobe acceptance SHALL occur on a rising edge of STB_I, i.e. STB_I=1 this cycle and 0 the previous cycle; holding STB_I high SHALL accept once.
REQ-011 On acceptance, DAT_I SHALL be captured that same edge; ACK_O SHALL be 1 for exactly the following cycle.
REQ-012 Two states: IDLE (no pattern, o_led=0) and RUN (pattern playing).
REQ-013 IDLE + accept with DAT_I!=0: active mask <= DAT_I, bit index <= 7, prescaler <= 0, state <= RUN; o_led SHALL equal DAT_I[7] the next cycle.
REQ-014 IDLE + accept with DAT_I==0: state stays IDLE; ACK_O and o_alive still respond.
REQ-015 Prescaler SHALL count 0..TICK_COUNT-1 in RUN and issue a one-cycle tick when at TICK_COUNT-1, then wrap to 0; it SHALL hold 0 in IDLE.
REQ-016 On each tick, bit index SHALL decrement 7->0; o_led SHALL be active_mask[bit index], registered.
REQ-017 Tick at index 0 (pattern boundary): index wraps to 7; if pending valid, active <= pending and pending cleared; if the resulting mask is 0, state <= IDLE and o_led <= 0.
REQ-018 RUN + accept (not on a boundary tick): pending <= DAT_I, pending valid <= 1; an existing pending value SHALL be overwritten (last writer wins).
REQ-019 Accept coinciding with a boundary tick: DAT_I SHALL load directly into active mask (priority over pending), pending cleared, index 7.
REQ-020 A pattern SHALL repeat indefinitely while no new mask arrives; one full pattern lasts 8*TICK_COUNT cycles.
REQ-021 o_busy SHALL be combinationally equal to (state == RUN).
REQ-022 Prescaler width SHALL be ceil(log2(TICK_COUNT)) bits; no overflow beyond TICK_COUNT-1.

Reset
REQ-023 While RST_I=0, all registers SHALL be forced immediately, independent of CLK_I.
REQ-024 Reset values: state IDLE, o_led 0, ACK_O 0, o_busy 0, o_alive 1, active and pending mask 0x00, pending valid 0, index 7, prescaler 0, previous-STB_I register 0.
REQ-025 With previous-STB_I cleared, STB_I held high across reset release SHALL be accepted on the first clock edge after release.
REQ-026 Reset mid-pattern SHALL abandon the pattern and any pending mask with no further ACK_O.

Structure
REQ-027 Package prewish5k_pkg SHALL hold the state encoding (IDLE, RUN), the mask width constant (8) and the bit-index reset constant (7).
REQ-028 Prescaler SHALL be a sub-module prewish5k_prescaler (parameter TICK_COUNT; inputs clock, reset, enable; output tick).
REQ-029 No other sub-modules; total RTL 120-400 lines.

Verification (TICK_COUNT=4)
REQ-030 Reset release, STB_I low -> o_led 0, o_busy 0, o_alive 1, ACK_O never pulses.
REQ-031 One-cycle strobe DAT_I=0xA5 -> ACK_O one cycle; o_led sequence 1,0,1,0,0,1,0,1 each held 4 cycles, repeating; o_alive 0.
REQ-032 STB_I held high 10 cycles with DAT_I=0x81 -> exactly one ACK_O, o_alive toggles once.
REQ-033 Playing 0xF0, strobes 0x0F then 0x3C mid-pattern -> two ACK_O; current pattern completes, next pattern is 0x3C (0x0F discarded).
REQ-034 Playing 0xFF, strobe 0x00 -> pattern finishes, then o_busy 0, o_led 0; strobe landing exactly on boundary tick loads immediately.
REQ-035 RST_I low mid-pattern with pending valid -> o_led 0 asynchronously; after release, IDLE with no residual pattern.

Source files
------------

// File: rtl/prewish5k_pkg.sv
// Shared encodings for the prewish5k LED blinker: FSM states and mask geometry.
package prewish5k_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int              MASK_W  = 8;
    localparam int              IDX_W   = $clog2(MASK_W);
    localparam logic [IDX_W-1:0] IDX_RST = IDX_W'(MASK_W - 1);

endpackage

// File: rtl/prewish5k_prescaler.sv
// Bit-period prescaler: counts 0..TICK_COUNT-1 while enabled, ticks on the last count.
module prewish5k_prescaler #(
    parameter int TICK_COUNT = 1500000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_tick
);

    localparam int              CNT_W = $clog2(TICK_COUNT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_COUNT - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_tick = i_en && (r_cnt == LAST);

    // Held at zero while disabled so every pattern starts on a full bit-period.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)     r_cnt <= '0;
        else if (!i_en)   r_cnt <= '0;
        else if (o_tick)  r_cnt <= '0;
        else              r_cnt <= r_cnt + CNT_W'(1);
    end

endmodule

// File: rtl/prewish5k_blinky.sv
// Strobe-loaded 8-bit blink pattern player with a one-deep pending mask.
module prewish5k_blinky
    import prewish5k_pkg::*;
#(
    parameter int TICK_COUNT = 1500000
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic              STB_I,
    input  logic [MASK_W-1:0] DAT_I,
    output logic              ACK_O,
    output logic              o_led,
    output logic              o_busy,
    output logic              o_alive
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_stb_prev;
    logic [MASK_W-1:0] r_active;
    logic [MASK_W-1:0] r_pend;
    logic              r_pend_vld;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_dec;
    logic [MASK_W-1:0] w_next_mask;
    logic              w_accept;
    logic              w_tick;
    logic              w_boundary;

    assign w_accept   = STB_I && !r_stb_prev;
    assign w_boundary = w_tick && (r_idx == '0);
    assign w_idx_dec  = r_idx - IDX_W'(1);
    assign o_busy     = (r_state == ST_RUN);

    prewish5k_prescaler #(
        .TICK_COUNT (TICK_COUNT)
    ) u_prescaler (
        .i_clk   (CLK_I),
        .i_rst_n (RST_I),
        .i_en    (o_busy),
        .o_tick  (w_tick)
    );

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // A strobe landing on the boundary tick beats any pending mask.
    always_comb begin
        w_state_nxt = r_state;
        w_next_mask = r_active;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && (DAT_I != '0)) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_boundary) begin
                    if (w_accept)        w_next_mask = DAT_I;
                    else if (r_pend_vld) w_next_mask = r_pend;
                    if (w_next_mask == '0) w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_stb_prev <= 1'b0;
            ACK_O      <= 1'b0;
            o_alive    <= 1'b1;
            o_led      <= 1'b0;
            r_active   <= '0;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_idx      <= IDX_RST;
        end else begin
            r_stb_prev <= STB_I;
            ACK_O      <= w_accept;
            if (w_accept) o_alive <= ~o_alive;

            if (r_state == ST_IDLE) begin
                if (w_accept && (DAT_I != '0)) begin
                    r_active <= DAT_I;
                    r_idx    <= IDX_RST;
                    o_led    <= DAT_I[MASK_W-1];
                end
            end else if (w_boundary) begin
                // An all-zero next mask drives the LED low as the FSM drops to IDLE.
                r_active   <= w_next_mask;
                r_pend     <= '0;
                r_pend_vld <= 1'b0;
                r_idx      <= IDX_RST;
                o_led      <= w_next_mask[MASK_W-1];
            end else begin
                if (w_accept) begin
                    r_pend     <= DAT_I;
                    r_pend_vld <= 1'b1;
                end
                if (w_tick) begin
                    r_idx <= w_idx_dec;
                    o_led <= r_active[w_idx_dec];
                end
            end
        end
    end

endmodule

// File: tb/tb_prewish5k_blinky.sv
// Self-checking bench for prewish5k_blinky at TICK_COUNT=4: vector table plus corner sequences.
module tb_prewish5k_blinky;

    localparam int TC  = 4;
    localparam int PAT = 8 * TC;

    logic       CLK_I;
    logic       RST_I;
    logic       STB_I;
    logic [7:0] DAT_I;
    logic       ACK_O;
    logic       o_led;
    logic       o_busy;
    logic       o_alive;

    prewish5k_blinky #(.TICK_COUNT(TC)) dut (
        .CLK_I   (CLK_I),
        .RST_I   (RST_I),
        .STB_I   (STB_I),
        .DAT_I   (DAT_I),
        .ACK_O   (ACK_O),
        .o_led   (o_led),
        .o_busy  (o_busy),
        .o_alive (o_alive)
    );

    initial CLK_I = 1'b0;
    always #5 CLK_I = ~CLK_I;

    typedef struct {
        logic led;
        logic busy;
        logic ack;
        logic ack_chk;
    } exp_t;

    typedef struct {
        logic [7:0] mask;
        int         reps;
    } vec_t;

    exp_t  sb[$];
    vec_t  vt[5];
    int    n_cmp = 0;
    int    n_err = 0;
    int    n_ack = 0;
    string tag   = "init";

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s/%s: got %0h want %0h", tag, nm, act, exp);
        end
    endtask

    // Expected LED stream for one full pattern: each mask bit, MSB first, held TC cycles.
    task automatic push_pattern(input logic [7:0] m, input bit ack_chk, input bit ack_first);
        exp_t e;
        for (int i = 0; i < PAT; i++) begin
            int b;
            b         = 7 - i / TC;
            e.busy    = (m != 8'h00);
            e.led     = e.busy ? m[b] : 1'b0;
            e.ack     = ack_first && (i == 0);
            e.ack_chk = ack_chk;
            sb.push_back(e);
        end
    endtask

    task automatic push_idle(input int n);
        exp_t e;
        e.led = 1'b0; e.busy = 1'b0; e.ack = 1'b0; e.ack_chk = 1'b1;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    // Drive at a negedge, let one rising edge pass, compare at the next negedge.
    task automatic cyc(input logic stb, input logic [7:0] dat);
        exp_t e;
        STB_I = stb;
        DAT_I = dat;
        @(negedge CLK_I);
        if (ACK_O === 1'b1) n_ack++;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s/scoreboard: got empty want entry", tag);
        end else begin
            e = sb.pop_front();
            check("led", o_led, e.led);
            check("busy", o_busy, e.busy);
            if (e.ack_chk) check("ack", ACK_O, e.ack);
        end
    endtask

    task automatic do_reset(input logic stb, input logic [7:0] dat);
        RST_I = 1'b0;
        STB_I = stb;
        DAT_I = dat;
        repeat (2) @(negedge CLK_I);
        check("rst_led", o_led, 0);
        check("rst_busy", o_busy, 0);
        check("rst_alive", o_alive, 1);
        check("rst_ack", ACK_O, 0);
        RST_I = 1'b1;
        sb.delete();
        n_ack = 0;
    endtask

    initial begin
        RST_I = 1'b0;
        STB_I = 1'b0;
        DAT_I = 8'h00;

        vt[0] = '{8'hA5, 2};
        vt[1] = '{8'h81, 1};
        vt[2] = '{8'h00, 1};
        vt[3] = '{8'h3C, 1};
        vt[4] = '{8'hFF, 1};

        // Quiet after reset: nothing plays, no acknowledge.
        tag = "idle";
        do_reset(1'b0, 8'h00);
        push_idle(10);
        for (int c = 0; c < 10; c++) cyc(1'b0, 8'h00);
        check("alive", o_alive, 1);
        check("acks", n_ack, 0);

        // Single one-cycle strobe per vector, pattern followed for reps periods.
        for (int v = 0; v < 5; v++) begin
            do_reset(1'b0, 8'h00);
            tag = $sformatf("vec%0d", v);
            for (int r = 0; r < vt[v].reps; r++) push_pattern(vt[v].mask, 1'b1, r == 0);
            cyc(1'b1, vt[v].mask);
            for (int c = 1; c < PAT * vt[v].reps; c++) cyc(1'b0, 8'h00);
            check("alive", o_alive, 0);
        end

        // Strobe held high across reset release and for 10 cycles: one accept.
        tag = "held";
        do_reset(1'b1, 8'h81);
        push_pattern(8'h81, 1'b1, 1'b1);
        for (int c = 0; c < 10; c++) cyc(1'b1, 8'h81);
        for (int c = 10; c < PAT; c++) cyc(1'b0, 8'h00);
        check("alive", o_alive, 0);
        check("acks", n_ack, 1);

        // Last pending writer wins; current pattern completes first.
        tag = "pend";
        do_reset(1'b0, 8'h00);
        push_pattern(8'hF0, 1'b0, 1'b0);
        push_pattern(8'h3C, 1'b0, 1'b0);
        push_pattern(8'h3C, 1'b0, 1'b0);
        for (int c = 1; c <= 3 * PAT; c++)
            cyc((c == 1) || (c == 5) || (c == 10),
                (c == 1) ? 8'hF0 : (c == 5) ? 8'h0F : (c == 10) ? 8'h3C : 8'h00);
        check("acks", n_ack, 3);

        // Zero mask queued: finish pattern, then idle.
        tag = "stop";
        do_reset(1'b0, 8'h00);
        push_pattern(8'hFF, 1'b0, 1'b0);
        push_idle(8);
        for (int c = 1; c <= PAT + 8; c++)
            cyc((c == 1) || (c == 6), (c == 1) ? 8'hFF : 8'h00);
        check("acks", n_ack, 2);

        // Strobe exactly on the boundary tick overrides the pending mask.
        tag = "bound";
        do_reset(1'b0, 8'h00);
        push_pattern(8'hFF, 1'b0, 1'b0);
        push_pattern(8'h0F, 1'b0, 1'b0);
        push_pattern(8'h0F, 1'b0, 1'b0);
        for (int c = 1; c <= 3 * PAT; c++)
            cyc((c == 1) || (c == 10) || (c == PAT + 1),
                (c == 1) ? 8'hFF : (c == 10) ? 8'hAA : (c == PAT + 1) ? 8'h0F : 8'h00);
        check("acks", n_ack, 3);

        // Asynchronous reset mid-pattern with a pending mask.
        tag = "areset";
        do_reset(1'b0, 8'h00);
        push_pattern(8'hFF, 1'b0, 1'b0);
        for (int c = 1; c <= 9; c++) cyc(c == 1 || c == 5, (c == 1) ? 8'hFF : 8'hAA);
        check("pre_led", o_led, 1);
        #1 RST_I = 1'b0;
        #1;
        check("async_led", o_led, 0);
        check("async_busy", o_busy, 0);
        check("async_alive", o_alive, 1);
        repeat (2) @(negedge CLK_I);
        RST_I = 1'b1;
        sb.delete();
        n_ack = 0;
        push_idle(2 * PAT);
        for (int c = 0; c < 2 * PAT; c++) cyc(1'b0, 8'h00);
        check("acks", n_ack, 0);
        check("alive", o_alive, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
